imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Debug-side writer for the instruction memory in the fetch stage.
- Takes a byte stream from the debug UART receiver and assembles big-endian 32-bit instruction words.
- Drives the fetch-stage debug select, memory write-enable, write address and write data until a HALT word has been written.
- While loading, it owns the instruction-memory address mux; the pipeline stays disabled externally.

Parameters:
- NB_INST, 32: instruction width in bits (4 bytes).
- NB_ADDR, `ADDRWIDTH: instruction-memory address width.
- MEM_DEPTH, `N_ELEMENTS: number of writable word locations.
- HALT_INSTR, 32'hFC000000: end-of-program word.

Ports:
- i_clk  in  1  system clock.
- i_reset  in  1  asynchronous, active-high reset.
- i_start  in  1  single-cycle pulse that starts a load session.
- i_rx_data  in  8  received byte.
- i_rx_valid  in  1  one-cycle strobe; i_rx_data is valid this cycle.
- o_debug_unit  out  1  selects the loader address on the imem address mux.
- o_mem_wen  out  1  imem write enable, one cycle per word.
- o_wr_addr  out  NB_ADDR  imem write address.
- o_mem_data  out  NB_INST  imem write data.
- o_words_loaded  out  NB_ADDR+1  number of words written this session.
- o_load_done  out  1  level; HALT word has been written.
- o_overflow  out  1  level; memory filled without a HALT word.

Behaviour:
- Reset: asynchronous, active-high; takes effect immediately, including mid-load. State becomes IDLE. All outputs go to 0; the internal byte counter, word buffer and address are cleared.
- States: IDLE, LOAD, WRITE, DONE, ERR.
- IDLE:
  - o_debug_unit=0; i_rx_valid is ignored.
  - i_start -> LOAD. Clears address, o_words_loaded, byte counter, o_load_done and o_overflow.
- LOAD:
  - o_debug_unit=1.
  - Each i_rx_valid: buffer <= {buffer[23:0], i_rx_data}, byte counter +1 (mod 4). The first byte received ends up as bits [31:24].
  - When the 4th byte is accepted -> WRITE on the next edge.
- WRITE (exactly one cycle):
  - o_mem_wen=1, o_wr_addr=current address, o_mem_data=assembled word; o_words_loaded increments at the end of the cycle.
  - Latency: 4th-byte strobe in cycle N -> o_mem_wen high in cycle N+1.
  - Next state, in priority order:
    - word==HALT_INSTR -> DONE.
    - else address==MEM_DEPTH-1 -> ERR.
    - else address+1 -> LOAD.
  - A byte strobed during WRITE is accepted as byte 0 of the next word only when the next state is LOAD; otherwise it is dropped.
- o_wr_addr and o_mem_data hold their last values outside WRITE. o_mem_wen is 0 in every state except WRITE.
- DONE: o_debug_unit=0, o_load_done=1 (held); bytes are ignored; i_start -> LOAD (new session).
- ERR: o_debug_unit=0, o_overflow=1 (held); bytes are ignored; i_start -> LOAD.
- i_start in LOAD or WRITE is ignored; there is no mid-session restart except reset.
- A partial word (1-3 bytes) pending at reset is discarded and nothing is written.
- Address arithmetic: word-indexed, +1 per word, never wraps; exceeding the last location goes to ERR.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- Enabled:
  - An 8-bit XOR accumulator over every accepted program byte; it is cleared on i_start and on reset.
  - After the HALT write, the state CHECK waits for one more byte and compares it with the accumulator.
  - Match -> DONE with o_load_done=1. Mismatch -> ERR, and the extra output o_chk_err (1 bit, reset 0, held) is set; o_overflow stays 0.
  - o_debug_unit stays 1 during CHECK.
- Disabled: no CHECK state, no accumulator, no o_chk_err port; HALT -> DONE directly.

Test Plan:
- Load two words plus HALT:
  - Stimulus: i_start, then bytes 20 01 00 05 / 8C 02 00 04 / FC 00 00 00.
  - Required: writes (addr 0, 32'h20010005), (addr 1, 32'h8C020004), (addr 2, 32'hFC000000); o_mem_wen high one cycle each, in cycle N+1 after each 4th byte; o_words_loaded=3; o_load_done=1; o_debug_unit falls.
- Back-to-back bytes:
  - Stimulus: i_rx_valid high every cycle, including the WRITE cycle.
  - Required: no byte lost; second word assembled correctly and written at addr 1.
- Overflow with MEM_DEPTH=4:
  - Stimulus: 4 non-HALT words.
  - Required: writes at addr 0-3, then o_overflow=1, o_load_done=0, o_debug_unit=0; the 5th word's bytes are ignored.
- Reset mid-load:
  - Stimulus: i_start, 6 bytes, then assert i_reset asynchronously between edges.
  - Required: all outputs 0 immediately, only one write issued (addr 0). A fresh i_start then writes the next complete word at addr 0.
- Restart and ignore:
  - Stimulus: i_start pulses during LOAD, then again after DONE.
  - Required: the pulse during LOAD has no effect; the pulse after DONE clears o_load_done, resets o_words_loaded to 0, and the next write goes to addr 0.
- Checksum (LOADER_CHECKSUM_EN):
  - Stimulus: program FC 00 00 00 followed by checksum byte FC.
  - Required: o_load_done=1.
  - Variant: checksum byte 00. Required: o_chk_err=1, ERR state, o_load_done=0.

Source files
------------

// File: rtl/imem_loader.sv
// Debug-side instruction memory loader: assembles big-endian words from UART bytes.
// Optional LOADER_CHECKSUM_EN adds an XOR checksum byte check after the HALT word.
`ifndef ADDRWIDTH
`define ADDRWIDTH 10
`endif
`ifndef N_ELEMENTS
`define N_ELEMENTS 1024
`endif

module imem_loader #(
    parameter int                 NB_INST    = 32,
    parameter int                 NB_ADDR    = `ADDRWIDTH,
    parameter int                 MEM_DEPTH  = `N_ELEMENTS,
    parameter logic [NB_INST-1:0] HALT_INSTR = 32'hFC000000
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic [7:0]         i_rx_data,
    input  logic               i_rx_valid,
    output logic               o_debug_unit,
    output logic               o_mem_wen,
    output logic [NB_ADDR-1:0] o_wr_addr,
    output logic [NB_INST-1:0] o_mem_data,
    output logic [NB_ADDR:0]   o_words_loaded,
    output logic               o_load_done,
`ifdef LOADER_CHECKSUM_EN
    output logic               o_chk_err,
`endif
    output logic               o_overflow
);

`ifdef LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        IDLE, LOAD, WRITE, DONE, ERR, CHECK
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE, LOAD, WRITE, DONE, ERR
    } state_t;
`endif

    localparam logic [1:0]         LAST_BYTE = 2'(NB_INST / 8 - 1);
    localparam logic [NB_ADDR-1:0] LAST_ADDR = NB_ADDR'(MEM_DEPTH - 1);
    localparam logic [NB_ADDR-1:0] ADDR_ONE  = 1;
    localparam logic [NB_ADDR:0]   WORD_ONE  = 1;

    state_t               state;
    state_t               state_d;
    logic [NB_INST-1:0]   buffer;
    logic [1:0]           byte_cnt;
    logic [NB_ADDR-1:0]   addr;
    logic                 accept;
    logic                 start;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]           acc;
`endif

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d      = state;
        accept       = 1'b0;
        start        = 1'b0;
        o_debug_unit = 1'b0;
        o_mem_wen    = 1'b0;
        unique case (state)
            IDLE, DONE, ERR: begin
                if (i_start) begin
                    start   = 1'b1;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                o_debug_unit = 1'b1;
                if (i_rx_valid) begin
                    accept = 1'b1;
                    if (byte_cnt == LAST_BYTE) begin
                        state_d = WRITE;
                    end
                end
            end
            WRITE: begin
                o_debug_unit = 1'b1;
                o_mem_wen    = 1'b1;
                if (o_mem_data == HALT_INSTR) begin
`ifdef LOADER_CHECKSUM_EN
                    state_d = CHECK;
`else
                    state_d = DONE;
`endif
                end else if (addr == LAST_ADDR) begin
                    state_d = ERR;
                end else begin
                    // byte counter is already back at 0 here
                    state_d = LOAD;
                    accept  = i_rx_valid;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            CHECK: begin
                o_debug_unit = 1'b1;
                if (i_rx_valid) begin
                    state_d = (i_rx_data == acc) ? DONE : ERR;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            buffer         <= '0;
            byte_cnt       <= '0;
            addr           <= '0;
            o_wr_addr      <= '0;
            o_mem_data     <= '0;
            o_words_loaded <= '0;
            o_load_done    <= 1'b0;
            o_overflow     <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            acc            <= '0;
            o_chk_err      <= 1'b0;
`endif
        end else begin
            if (start) begin
                addr           <= '0;
                byte_cnt       <= '0;
                o_words_loaded <= '0;
                o_load_done    <= 1'b0;
                o_overflow     <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
                acc            <= '0;
                o_chk_err      <= 1'b0;
`endif
            end
            if (accept) begin
                buffer   <= {buffer[NB_INST-9:0], i_rx_data};
                byte_cnt <= byte_cnt + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                acc      <= acc ^ i_rx_data;
`endif
                // latch the write port on the last byte so WRITE sees it
                if (byte_cnt == LAST_BYTE) begin
                    o_wr_addr  <= addr;
                    o_mem_data <= {buffer[NB_INST-9:0], i_rx_data};
                end
            end
            if (state == WRITE) begin
                o_words_loaded <= o_words_loaded + WORD_ONE;
                if (state_d == LOAD) begin
                    addr <= addr + ADDR_ONE;
                end
                if (state_d == ERR) begin
                    o_overflow <= 1'b1;
                end
            end
            if (state_d == DONE && state != DONE) begin
                o_load_done <= 1'b1;
            end
`ifdef LOADER_CHECKSUM_EN
            if (state == CHECK && state_d == ERR) begin
                o_chk_err <= 1'b1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader with a 4-word memory.
// Checksum cases run only when LOADER_CHECKSUM_EN is defined.
`timescale 1ns/1ps
module tb_imem_loader;

    localparam int NB_ADDR = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [7:0]        rx_data = '0;
    logic              rx_valid = 1'b0;
    logic              debug_unit;
    logic              mem_wen;
    logic [NB_ADDR-1:0] wr_addr;
    logic [31:0]       mem_data;
    logic [NB_ADDR:0]  words_loaded;
    logic              load_done;
    logic              overflow;
`ifdef LOADER_CHECKSUM_EN
    logic              chk_err;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    logic [NB_ADDR-1:0] wa[$];
    logic [31:0]        wd[$];
    int sz;

    imem_loader #(
        .NB_INST(32), .NB_ADDR(NB_ADDR), .MEM_DEPTH(4),
        .HALT_INSTR(32'hFC000000)
    ) dut (
        .i_clk(clk), .i_reset(rst), .i_start(start),
        .i_rx_data(rx_data), .i_rx_valid(rx_valid),
        .o_debug_unit(debug_unit), .o_mem_wen(mem_wen),
        .o_wr_addr(wr_addr), .o_mem_data(mem_data),
        .o_words_loaded(words_loaded), .o_load_done(load_done),
`ifdef LOADER_CHECKSUM_EN
        .o_chk_err(chk_err),
`endif
        .o_overflow(overflow)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mem_wen) begin
            wa.push_back(wr_addr);
            wd.push_back(mem_data);
        end
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic start_pulse();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1 rx_valid = 1'b1; rx_data = b;
        @(posedge clk); #1 rx_valid = 1'b0;
    endtask

    // expects WRITE in the cycle right after the 4th byte, for one cycle
    task automatic check_write(input string tag, input logic [3:0] a,
                               input logic [31:0] w);
        @(negedge clk);
        check({tag, "_wen"}, 64'(mem_wen), 64'd1);
        check({tag, "_addr"}, 64'(wr_addr), 64'(a));
        check({tag, "_data"}, 64'(mem_data), 64'(w));
        @(negedge clk);
        check({tag, "_wen_off"}, 64'(mem_wen), 64'd0);
    endtask

    task automatic send_word(input string tag, input logic [31:0] w,
                             input logic [3:0] a);
        for (int i = 0; i < 4; i++) send_byte(w[31-8*i -: 8]);
        check_write(tag, a, w);
    endtask

    task automatic burst(input logic [63:0] bytes);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1 rx_valid = 1'b1; rx_data = bytes[63-8*i -: 8];
        end
        @(posedge clk); #1 rx_valid = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_debug", 64'(debug_unit), 64'd0);
        check("rst_wen", 64'(mem_wen), 64'd0);
        check("rst_words", 64'(words_loaded), 64'd0);
        check("rst_done", 64'(load_done), 64'd0);
        check("rst_ovf", 64'(overflow), 64'd0);
        check("rst_data", 64'(mem_data), 64'd0);
        rst = 1'b0;

        // IDLE ignores bytes
        send_byte(8'h55);
        check("idle_debug", 64'(debug_unit), 64'd0);
        check("idle_nowrite", 64'(wa.size()), 64'd0);

        // two words plus HALT
        start_pulse();
        check("load_debug", 64'(debug_unit), 64'd1);
        send_word("w0", 32'h20010005, 4'd0);
        send_word("w1", 32'h8C020004, 4'd1);
        send_word("w2", 32'hFC000000, 4'd2);
        check("p1_words", 64'(words_loaded), 64'd3);
`ifdef LOADER_CHECKSUM_EN
        check("p1_chk_debug", 64'(debug_unit), 64'd1);
        check("p1_chk_wait", 64'(load_done), 64'd0);
        send_byte(8'h52);
        @(negedge clk);
`endif
        check("p1_done", 64'(load_done), 64'd1);
        check("p1_debug_fall", 64'(debug_unit), 64'd0);

        // restart after DONE, start during LOAD ignored
        start_pulse();
        check("rs_done_clr", 64'(load_done), 64'd0);
        check("rs_words_clr", 64'(words_loaded), 64'd0);
        send_byte(8'h12);
        send_byte(8'h34);
        start_pulse();
        send_byte(8'h56);
        send_byte(8'h78);
        check_write("ign", 4'd0, 32'h12345678);

        // back-to-back bytes including the WRITE cycle
        wa.delete();
        wd.delete();
        burst(64'h1122334455667788);
        repeat (2) @(negedge clk);
        check("b2b_n", 64'(wa.size()), 64'd2);
        if (wa.size() == 2) begin
            check("b2b_a0", 64'(wa[0]), 64'd1);
            check("b2b_d0", 64'(wd[0]), 64'h11223344);
            check("b2b_a1", 64'(wa[1]), 64'd2);
            check("b2b_d1", 64'(wd[1]), 64'h55667788);
        end
        check("b2b_words", 64'(words_loaded), 64'd3);

        // last location without HALT -> overflow
        send_word("w3", 32'hAABBCCDD, 4'd3);
        check("ovf_flag", 64'(overflow), 64'd1);
        check("ovf_done", 64'(load_done), 64'd0);
        check("ovf_debug", 64'(debug_unit), 64'd0);
        sz = wa.size();
        for (int i = 0; i < 4; i++) send_byte(8'hA0 + 8'(i));
        repeat (2) @(negedge clk);
        check("ovf_ignored", 64'(wa.size()), 64'(sz));
        check("ovf_words", 64'(words_loaded), 64'd4);

        // reset in the middle of the second word
        start_pulse();
        check("ovf_clr", 64'(overflow), 64'd0);
        wa.delete();
        wd.delete();
        send_word("rm0", 32'h01020304, 4'd0);
        send_byte(8'h05);
        send_byte(8'h06);
        #3 rst = 1'b1;
        #1;
        check("rm_debug", 64'(debug_unit), 64'd0);
        check("rm_wen", 64'(mem_wen), 64'd0);
        check("rm_addr", 64'(wr_addr), 64'd0);
        check("rm_data", 64'(mem_data), 64'd0);
        check("rm_words", 64'(words_loaded), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rm_one_write", 64'(wa.size()), 64'd1);
        start_pulse();
        send_word("rm1", 32'h0A0B0C0D, 4'd0);
        send_word("rm2", 32'hFC000000, 4'd1);
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'hFC);
        @(negedge clk);
`endif
        check("rm_done", 64'(load_done), 64'd1);

`ifdef LOADER_CHECKSUM_EN
        start_pulse();
        send_word("ck0", 32'hFC000000, 4'd0);
        send_byte(8'hFC);
        @(negedge clk);
        check("ck_ok_done", 64'(load_done), 64'd1);
        check("ck_ok_err", 64'(chk_err), 64'd0);
        start_pulse();
        send_word("ck1", 32'hFC000000, 4'd0);
        send_byte(8'h00);
        @(negedge clk);
        check("ck_bad_err", 64'(chk_err), 64'd1);
        check("ck_bad_done", 64'(load_done), 64'd0);
        check("ck_bad_ovf", 64'(overflow), 64'd0);
        check("ck_bad_debug", 64'(debug_unit), 64'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
